hyper_delay_pipe: RTL and testbench

- Fixed-latency, register-only delay line: a WIDTH-bit word presented on din appears on dout exactly NUM_PIPES clock cycles later.
- Used beside memory-read paths to carry per-request sideband (packet flags, header length) aligned with read data. Typical latency is 7 for BRAM builds and 17 for eSRAM builds.
- No handshake and no stall: the pipe advances every cycle.
- Every stage is a plain register, so synthesis can retime or hyper-register it.

---
 rtl/hyper_delay_pipe_pkg.sv | 19 +
 rtl/hyper_pipe_stage.sv | 38 +++
 rtl/hyper_delay_pipe.sv | 129 ++++++++++++
 tb/tb_hyper_delay_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hyper_delay_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hyper_delay_pipe_pkg
// Description : Shared constants for the hyper_delay_pipe delay line. Holds
//               the legal-range limits so instantiating code can check its
//               own parameters against the same numbers the pipe uses.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hyper_delay_pipe_pkg;

  // Widest data word the pipe is qualified for.
  localparam int c_max_width = 1024;

  // Deepest latency the pipe is qualified for.
  localparam int c_max_pipes = 64;

endpackage : hyper_delay_pipe_pkg
`default_nettype wire

// File: rtl/hyper_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : hyper_pipe_stage
// Description : One plain WIDTH-bit register with asynchronous active-high
//               reset to RESET_VAL. No logic on d or q, so synthesis is free
//               to retime the register or map it onto a hyper-register.
// Ports       : clk - rising-edge clock
//               rst - asynchronous active-high reset
//               d   - stage input
//               q   - stage output (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module hyper_pipe_stage
  import hyper_delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : hyper_pipe_stage
`default_nettype wire

// File: rtl/hyper_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hyper_delay_pipe
// Description : Fixed-latency, register-only delay line. din appears on dout
//               exactly NUM_PIPES rising edges later; the pipe shifts every
//               cycle with no enable or backpressure. NUM_PIPES == 0 gives a
//               combinational pass-through.
//               Optional feature macro: HYPER_PIPE_VALID_EN adds a parallel
//               valid chain and an in-flight counter. The data path is
//               identical with or without the macro.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset (stages load
//                            RESET_VAL immediately)
//               din        - WIDTH-bit data into stage 0
//               dout       - WIDTH-bit data out of the last stage
//               din_valid  - (HYPER_PIPE_VALID_EN) qualifier sampled with din
//               dout_valid - (HYPER_PIPE_VALID_EN) din_valid delayed
//                            NUM_PIPES cycles
//               inflight   - (HYPER_PIPE_VALID_EN) valid words in the pipe
// Revision    : 1.0 - initial release
// ============================================================================
module hyper_delay_pipe
  import hyper_delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NUM_PIPES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  // Counter width is $clog2(NUM_PIPES+1); kept at least 1 bit so the
  // pass-through build still has a legal port.
  localparam int              c_cnt_w   = (NUM_PIPES < 1) ? 1 : $clog2(NUM_PIPES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
`ifdef HYPER_PIPE_VALID_EN
  ,
  input  logic               din_valid,
  output logic               dout_valid,
  output logic [c_cnt_w-1:0] inflight
`endif
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_chk_width
    $fatal(1, "hyper_delay_pipe: WIDTH must be at least 1");
  end

  if ((NUM_PIPES < 0) || (NUM_PIPES > c_max_pipes)) begin : g_chk_pipes
    $fatal(1, "hyper_delay_pipe: NUM_PIPES out of range 0..%0d", c_max_pipes);
  end

  // --------------------------------------------------------------------------
  // Data chain
  // --------------------------------------------------------------------------
  if (NUM_PIPES == 0) begin : g_data_passthru
    // No registers exist, so clk and rst have nothing to drive.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign dout = din;
  end else begin : g_data_chain
    // w_tap[0] is din; w_tap[i+1] is the output of stage i.
    logic [WIDTH-1:0] w_tap [NUM_PIPES+1];

    assign w_tap[0] = din;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_stage
      hyper_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (w_tap[i]),
        .q   (w_tap[i+1])
      );
    end

    assign dout = w_tap[NUM_PIPES];
  end

`ifdef HYPER_PIPE_VALID_EN
  // --------------------------------------------------------------------------
  // Valid chain and in-flight counter
  // --------------------------------------------------------------------------
  if (NUM_PIPES == 0) begin : g_valid_passthru
    assign dout_valid = din_valid;
    assign inflight   = '0;
  end else begin : g_valid_chain
    logic               w_vtap [NUM_PIPES+1];
    logic [c_cnt_w-1:0] r_inflight;

    assign w_vtap[0] = din_valid;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_vstage
      hyper_pipe_stage #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
      ) u_vstage (
        .clk (clk),
        .rst (rst),
        .d   (w_vtap[i]),
        .q   (w_vtap[i+1])
      );
    end

    // The counter tracks the number of set bits in the valid chain: a bit
    // entering adds one, the bit sitting in the last stage leaves on the same
    // edge. It therefore cannot exceed NUM_PIPES.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_inflight <= '0;
      end else if (din_valid && !w_vtap[NUM_PIPES]) begin
        r_inflight <= r_inflight + c_cnt_w'(1);
      end else if (!din_valid && w_vtap[NUM_PIPES]) begin
        r_inflight <= r_inflight - c_cnt_w'(1);
      end
    end

    assign dout_valid = w_vtap[NUM_PIPES];
    assign inflight   = r_inflight;
  end
`endif

endmodule : hyper_delay_pipe
`default_nettype wire

// File: tb/tb_hyper_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyper_delay_pipe
// Description : Self-checking bench for hyper_delay_pipe. Several instances
//               with different parameters share one clock; each is exercised
//               in turn by a linear directed sequence. Expected dout values
//               are queued when din is driven and popped once per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyper_delay_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: WIDTH=3, NUM_PIPES=7
  logic       rst_a;
  logic [2:0] din_a, dout_a;
  // Instance B: WIDTH=9, NUM_PIPES=17
  logic       rst_b;
  logic [8:0] din_b, dout_b;
  // Instance C: WIDTH=8, NUM_PIPES=0
  logic       rst_c;
  logic [7:0] din_c, dout_c;
  // Instance D: WIDTH=3, NUM_PIPES=7, RESET_VAL=3'b101
  logic       rst_d;
  logic [2:0] din_d, dout_d;

`ifdef HYPER_PIPE_VALID_EN
  logic       vo_a, vo_b, vo_c, vo_d;
  logic [2:0] inf_a, inf_d;
  logic [4:0] inf_b;
  logic [0:0] inf_c;
  // Instance E: WIDTH=8, NUM_PIPES=4 with valid chain
  logic       rst_e;
  logic [7:0] din_e, dout_e;
  logic       din_valid_e, dout_valid_e;
  logic [2:0] inflight_e;
`endif

  logic [31:0] q_exp[$];
  logic [31:0] q_vexp[$];

  hyper_delay_pipe #(.WIDTH(3), .NUM_PIPES(7), .RESET_VAL(3'b000)) u_a (
    .clk(clk), .rst(rst_a), .din(din_a), .dout(dout_a)
`ifdef HYPER_PIPE_VALID_EN
    , .din_valid(1'b0), .dout_valid(vo_a), .inflight(inf_a)
`endif
  );

  hyper_delay_pipe #(.WIDTH(9), .NUM_PIPES(17), .RESET_VAL(9'h000)) u_b (
    .clk(clk), .rst(rst_b), .din(din_b), .dout(dout_b)
`ifdef HYPER_PIPE_VALID_EN
    , .din_valid(1'b0), .dout_valid(vo_b), .inflight(inf_b)
`endif
  );

  hyper_delay_pipe #(.WIDTH(8), .NUM_PIPES(0), .RESET_VAL(8'h00)) u_c (
    .clk(clk), .rst(rst_c), .din(din_c), .dout(dout_c)
`ifdef HYPER_PIPE_VALID_EN
    , .din_valid(1'b0), .dout_valid(vo_c), .inflight(inf_c)
`endif
  );

  hyper_delay_pipe #(.WIDTH(3), .NUM_PIPES(7), .RESET_VAL(3'b101)) u_d (
    .clk(clk), .rst(rst_d), .din(din_d), .dout(dout_d)
`ifdef HYPER_PIPE_VALID_EN
    , .din_valid(1'b0), .dout_valid(vo_d), .inflight(inf_d)
`endif
  );

`ifdef HYPER_PIPE_VALID_EN
  hyper_delay_pipe #(.WIDTH(8), .NUM_PIPES(4), .RESET_VAL(8'h00)) u_e (
    .clk(clk), .rst(rst_e), .din(din_e), .dout(dout_e),
    .din_valid(din_valid_e), .dout_valid(dout_valid_e), .inflight(inflight_e)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef HYPER_PIPE_VALID_EN
  // valid pattern 1,1,0,1 then zeros; inflight = set bits in the 4-deep chain
  logic       v_pat   [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] exp_inf [9] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
`endif

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    din_a = '0;   din_b = '0;   din_c = '0;   din_d = '0;
`ifdef HYPER_PIPE_VALID_EN
    rst_e = 1'b0; din_e = '0; din_valid_e = 1'b0;
`endif
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
`ifdef HYPER_PIPE_VALID_EN
    rst_e = 1'b1;
`endif
    #1;
    // Reset takes effect before any clock edge.
    check("reset_a", 32'(dout_a), 32'h0);
    check("reset_d", 32'(dout_d), 32'h5);
`ifdef HYPER_PIPE_VALID_EN
    check("reset_vld", 32'(dout_valid_e), 32'h0);
    check("reset_inf", 32'(inflight_e), 32'h0);
`endif
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
`ifdef HYPER_PIPE_VALID_EN
    rst_e = 1'b0;
`endif

    // ---- A: ramp 0..7 through a 7-deep pipe --------------------------------
    // After edge k dout holds the word driven before edge k-6, so six reset
    // values are outstanding ahead of the first driven word.
    q_exp.delete();
    for (int i = 0; i < 6; i++) q_exp.push_back(32'h0);
    for (int i = 0; i < 14; i++) begin
      din_a = (i < 8) ? 3'(i) : 3'd0;
      q_exp.push_back(32'(din_a));
      tick();
      check("p7_ramp", 32'(dout_a), q_exp.pop_front());
    end

    // ---- B: single pulse through a 17-deep pipe ----------------------------
    q_exp.delete();
    for (int i = 0; i < 16; i++) q_exp.push_back(32'h0);
    for (int i = 0; i < 20; i++) begin
      din_b = (i == 0) ? 9'h1A5 : 9'h000;
      q_exp.push_back(32'(din_b));
      tick();
      check("p17_pulse", 32'(dout_b), q_exp.pop_front());
    end

    // ---- C: pass-through, no clock edge between changes --------------------
    din_c = 8'h3C;
    #1;
    check("p0_3c", 32'(dout_c), 32'h3C);
    din_c = 8'hC3;
    #1;
    check("p0_c3", 32'(dout_c), 32'hC3);
    rst_c = 1'b1;
    #1;
    check("p0_rst", 32'(dout_c), 32'hC3);
    rst_c = 1'b0;

    // ---- D: fill, asynchronous reset pulse, refill -------------------------
    tick();
    din_d = 3'b010;
    for (int i = 0; i < 8; i++) tick();
    check("rv_fill", 32'(dout_d), 32'h2);
    #2;
    rst_d = 1'b1;
    #1;
    check("rv_async", 32'(dout_d), 32'h5);
    din_d = 3'b011;
    #2;
    rst_d = 1'b0;
    #1;
    check("rv_release", 32'(dout_d), 32'h5);
    q_exp.delete();
    for (int i = 0; i < 6; i++) q_exp.push_back(32'h5);
    for (int i = 0; i < 10; i++) begin
      din_d = 3'b011;
      q_exp.push_back(32'(din_d));
      tick();
      check("rv_refill", 32'(dout_d), q_exp.pop_front());
    end

`ifdef HYPER_PIPE_VALID_EN
    // ---- E: valid chain and inflight count, 4-deep -------------------------
    q_exp.delete();
    q_vexp.delete();
    for (int i = 0; i < 3; i++) begin
      q_exp.push_back(32'h0);
      q_vexp.push_back(32'h0);
    end
    for (int i = 0; i < 9; i++) begin
      din_e       = 8'h40 + 8'(i);
      din_valid_e = v_pat[i];
      q_exp.push_back(32'(din_e));
      q_vexp.push_back(32'(din_valid_e));
      tick();
      check("v4_data", 32'(dout_e), q_exp.pop_front());
      check("v4_valid", 32'(dout_valid_e), q_vexp.pop_front());
      check("v4_inflight", 32'(inflight_e), 32'(exp_inf[i]));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_hyper_delay_pipe
`default_nettype wire
